// File: rtl/cbu_pkg.sv
// Shared definitions for the CBU and its instruction sequencer: instruction
// field layout, opcode encoding and the NOP word.
package cbu_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam int unsigned WORD_W  = 17;   // {instr[8:0], a[3:0], b[3:0]}

  localparam int unsigned OP_HI   = 8;
  localparam int unsigned OP_LO   = 6;
  localparam int unsigned SRC1_HI = 5;
  localparam int unsigned SRC1_LO = 4;
  localparam int unsigned SRC2_HI = 3;
  localparam int unsigned SRC2_LO = 2;
  localparam int unsigned DST_HI  = 1;
  localparam int unsigned DST_LO  = 0;

  localparam logic [INSTR_W-1:0] NOP      = '0;
  localparam logic [1:0]         REG_NONE = 2'b00;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_MUL2 = 3'b111
  } cbu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } seq_state_e;

  function automatic logic [1:0] fn_src1(input logic [INSTR_W-1:0] instr);
    return instr[SRC1_HI:SRC1_LO];
  endfunction

  function automatic logic [1:0] fn_src2(input logic [INSTR_W-1:0] instr);
    return instr[SRC2_HI:SRC2_LO];
  endfunction

  function automatic logic [1:0] fn_dst(input logic [INSTR_W-1:0] instr);
    return instr[DST_HI:DST_LO];
  endfunction

endpackage

// File: rtl/cbu_seq_mem.sv
// Program store for the sequencer: one synchronous write port, one
// asynchronous read port, no reset.
module cbu_seq_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned W     = 17
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cbu_sequencer.sv
// Instruction issuer for the CBU: streams a stored program one word per cycle,
// inserts hazard bubbles, aborts on illegal words and tags returning results.
module cbu_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PC_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [16:0]     prog_data,
  input  logic            start,
  input  logic [PC_W:0]   run_len,
  output logic [8:0]      cbu_in,
  output logic [3:0]      cbu_a,
  output logic [3:0]      cbu_b,
  input  logic [3:0]      cbu_out,
  output logic [3:0]      result,
  output logic [PC_W-1:0] result_tag,
  output logic            result_valid,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [7:0]      stall_cnt
);
  import cbu_pkg::*;

  localparam logic [PC_W:0] DEPTH_L = (PC_W+1)'(DEPTH);

  seq_state_e          state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W:0]       len_q, len_d;
  logic [INSTR_W-1:0]  in_q, in_d;
  logic [3:0]          a_q, a_d, b_q, b_d;
  logic [7:0]          stall_q, stall_d;
  logic                err_q, err_d;
  logic                abort_q, abort_d;
  logic                done_q, done_d;
  logic                push, push_res;

  // occ tracks every issued word so drain length is fixed; res marks words with a result
  logic [1:0]          occ_q;
  logic [2:0]          res_q;
  logic [PC_W-1:0]     tag_q [3];
  logic [3:0]          result_q;
  logic [PC_W-1:0]     rtag_q;
  logic                rv_q;

  logic [WORD_W-1:0]   cand;
  logic [INSTR_W-1:0]  cand_instr;
  logic [1:0]          cur_dst;
  logic                illegal, hazard;

  cbu_seq_mem #(
    .DEPTH (DEPTH),
    .AW    (PC_W),
    .W     (WORD_W)
  ) u_mem (
    .clk   (clk),
    .we    (prog_we && (state_q == S_IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (cand)
  );

  assign cand_instr = cand[16:8];
  assign cur_dst    = fn_dst(in_q);
  assign illegal    = (fn_src1(cand_instr) == fn_src2(cand_instr)) &&
                      (fn_src1(cand_instr) != REG_NONE);
  assign hazard     = (cur_dst != REG_NONE) &&
                      ((fn_src1(cand_instr) == cur_dst) || (fn_src2(cand_instr) == cur_dst));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    in_d     = NOP;
    a_d      = '0;
    b_d      = '0;
    stall_d  = stall_q;
    err_d    = err_q;
    abort_d  = abort_q;
    done_d   = 1'b0;
    push     = 1'b0;
    push_res = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((run_len == '0) || (run_len > DEPTH_L)) begin
            err_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            pc_d    = '0;
            len_d   = run_len;
            stall_d = '0;
            err_d   = 1'b0;
            abort_d = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        if (illegal) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = S_DRAIN;
        end else if (hazard) begin
          if (stall_q != 8'hFF) stall_d = stall_q + 8'd1;
        end else begin
          in_d     = cand_instr;
          a_d      = cand[7:4];
          b_d      = cand[3:0];
          push     = 1'b1;
          push_res = (fn_dst(cand_instr) != REG_NONE);
          pc_d     = pc_q + PC_W'(1);
          if ({1'b0, pc_q} == (len_q - (PC_W+1)'(1))) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // the oldest stage retires on this edge, so only the younger two must be empty
        if (!occ_q[0] && !occ_q[1]) begin
          state_d = S_IDLE;
          done_d  = !abort_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      in_q    <= NOP;
      a_q     <= '0;
      b_q     <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      in_q    <= in_d;
      a_q     <= a_d;
      b_q     <= b_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q    <= '0;
      res_q    <= '0;
      tag_q[0] <= '0;
      tag_q[1] <= '0;
      tag_q[2] <= '0;
      result_q <= '0;
      rtag_q   <= '0;
      rv_q     <= 1'b0;
    end else begin
      occ_q    <= {occ_q[0], push};
      res_q    <= {res_q[1:0], push_res};
      tag_q[0] <= pc_q;
      tag_q[1] <= tag_q[0];
      tag_q[2] <= tag_q[1];
      rv_q     <= res_q[2];
      if (res_q[2]) begin
        result_q <= cbu_out;
        rtag_q   <= tag_q[2];
      end
    end
  end

  assign cbu_in       = in_q;
  assign cbu_a        = a_q;
  assign cbu_b        = b_q;
  assign result       = result_q;
  assign result_tag   = rtag_q;
  assign result_valid = rv_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_cbu_sequencer.sv
// Directed bench for cbu_sequencer; a stand-in CBU returns a+b three cycles
// after a word appears on cbu_in.
module tb_cbu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [16:0] prog_data;
  logic        start;
  logic [4:0]  run_len;
  logic [8:0]  cbu_in;
  logic [3:0]  cbu_a, cbu_b, cbu_out;
  logic [3:0]  result;
  logic [3:0]  result_tag;
  logic        result_valid, busy, done, err;
  logic [7:0]  stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [3:0] p1;

  always #5 clk = ~clk;

  // stand-in CBU: registers the word at E+1, presents its result after E+2
  always @(posedge clk) begin
    p1      <= cbu_a + cbu_b;
    cbu_out <= p1;
  end

  cbu_sequencer #(.DEPTH(16), .PC_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .start        (start),
    .run_len      (run_len),
    .cbu_in       (cbu_in),
    .cbu_a        (cbu_a),
    .cbu_b        (cbu_b),
    .cbu_out      (cbu_out),
    .result       (result),
    .result_tag   (result_tag),
    .result_valid (result_valid),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .stall_cnt    (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [3:0] addr, input logic [16:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] len);
    start   = 1'b1;
    run_len = len;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    int k, done_at, dcount;
    logic [3:0] iv;
    p1 = '0; cbu_out = '0;
    rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; run_len = '0;
    tick(); tick();

    // reset state
    chk("rst_cbu_in", cbu_in, 9'h000);
    chk("rst_cbu_a", cbu_a, 4'd0);
    chk("rst_cbu_b", cbu_b, 4'd0);
    chk("rst_result", result, 4'd0);
    chk("rst_tag", result_tag, 4'd0);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_stall", stall_cnt, 8'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_cbu_in", cbu_in, 9'h000);

    // single add
    prog(4'd0, {9'h01B, 4'd3, 4'd4});
    do_start(5'd1);
    chk("add_busy", busy, 1'b1);
    chk("add_nop_s", cbu_in, 9'h000);
    tick();
    chk("add_in", cbu_in, 9'h01B);
    chk("add_a", cbu_a, 4'd3);
    chk("add_b", cbu_b, 4'd4);
    tick(); tick();
    chk("add_rv_early", result_valid, 1'b0);
    tick();
    chk("add_rv", result_valid, 1'b1);
    chk("add_res", result, 4'd7);
    chk("add_tag", result_tag, 4'd0);
    chk("add_done", done, 1'b1);
    chk("add_busy_end", busy, 1'b0);
    tick();
    chk("add_rv_off", result_valid, 1'b0);
    chk("add_done_off", done, 1'b0);

    // hazard bubble
    prog(4'd1, {9'h076, 4'd5, 4'd2});
    do_start(5'd2);
    tick();
    chk("haz_in0", cbu_in, 9'h01B);
    tick();
    chk("haz_bubble", cbu_in, 9'h000);
    chk("haz_stall", stall_cnt, 8'd1);
    tick();
    chk("haz_in1", cbu_in, 9'h076);
    tick();
    chk("haz_rv0", result_valid, 1'b1);
    chk("haz_res0", result, 4'd7);
    chk("haz_tag0", result_tag, 4'd0);
    tick();
    chk("haz_rv_gap", result_valid, 1'b0);
    chk("haz_busy_mid", busy, 1'b1);
    tick();
    chk("haz_rv1", result_valid, 1'b1);
    chk("haz_res1", result, 4'd7);
    chk("haz_tag1", result_tag, 4'd1);
    chk("haz_done", done, 1'b1);
    chk("haz_busy_end", busy, 1'b0);
    chk("haz_stall_hold", stall_cnt, 8'd1);

    // out-of-range run lengths
    do_start(5'd0);
    chk("len0_err", err, 1'b1);
    chk("len0_busy", busy, 1'b0);
    tick();
    chk("len0_done", done, 1'b0);
    do_start(5'd17);
    chk("len17_err", err, 1'b1);
    chk("len17_busy", busy, 1'b0);
    do_start(5'd1);
    chk("err_clear", err, 1'b0);
    chk("err_clear_busy", busy, 1'b1);
    chk("err_clear_stall", stall_cnt, 8'd0);
    tick(); tick(); tick(); tick();
    chk("err_clear_done", done, 1'b1);

    // illegal word aborts
    prog(4'd1, {9'h069, 4'd1, 4'd1});
    do_start(5'd2);
    tick();
    chk("ill_in0", cbu_in, 9'h01B);
    chk("ill_err_pre", err, 1'b0);
    tick();
    chk("ill_err", err, 1'b1);
    chk("ill_nop", cbu_in, 9'h000);
    chk("ill_busy", busy, 1'b1);
    tick();
    chk("ill_rv_early", result_valid, 1'b0);
    tick();
    chk("ill_rv0", result_valid, 1'b1);
    chk("ill_tag0", result_tag, 4'd0);
    chk("ill_res0", result, 4'd7);
    chk("ill_no_done", done, 1'b0);
    chk("ill_busy_end", busy, 1'b0);
    tick();
    chk("ill_rv_off", result_valid, 1'b0);
    chk("ill_done_off", done, 1'b0);
    chk("ill_err_sticky", err, 1'b1);

    // full length, alternating result / no-result words
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      if (i % 2 == 0) prog(iv, {9'h001, iv, 4'd1});
      else            prog(iv, {9'h040, iv, 4'd1});
    end
    do_start(5'd16);
    k = 0; done_at = 0; dcount = 0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 3) begin
        start = 1'b1; run_len = 5'd1;
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 17'h1FFFF;
      end
      tick();
      start = 1'b0; prog_we = 1'b0;
      if (result_valid) begin
        chk("full_tag", result_tag, 32'(2 * k));
        chk("full_res", result, 32'(2 * k + 1));
        k++;
      end
      if (done) begin
        dcount++;
        done_at = n;
      end
    end
    chk("full_count", k, 8);
    chk("full_done_at", done_at, 19);
    chk("full_done_cnt", dcount, 1);
    chk("full_busy_end", busy, 1'b0);
    chk("full_stall", stall_cnt, 8'd0);
    do_start(5'd1);
    tick();
    chk("full_mem0_in", cbu_in, 9'h001);
    chk("full_mem0_a", cbu_a, 4'd0);
    chk("full_mem0_b", cbu_b, 4'd1);
    tick(); tick(); tick();
    chk("full_rerun_done", done, 1'b1);

    // reset mid-run
    do_start(5'd16);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_cbu_in", cbu_in, 9'h000);
    chk("mrst_rv", result_valid, 1'b0);
    chk("mrst_done", done, 1'b0);
    tick();
    rst = 1'b1;
    k = 0; dcount = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (result_valid) k++;
      if (done) dcount++;
    end
    chk("mrst_no_rv", k, 0);
    chk("mrst_no_done", dcount, 0);
    chk("mrst_idle", busy, 1'b0);
    do_start(5'd1);
    tick();
    chk("mrst_rerun_in", cbu_in, 9'h001);
    tick(); tick(); tick();
    chk("mrst_rerun_rv", result_valid, 1'b1);
    chk("mrst_rerun_tag", result_tag, 4'd0);
    chk("mrst_rerun_res", result, 4'd1);
    chk("mrst_rerun_done", done, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbu_sequencer.md
# cbu_sequencer

Instruction issuer for the 3-register, 8-function CBU. It holds a 16-entry program of {instruction, a, b} words and streams them to the CBU one per cycle. It enforces the CBU's issue rules by inserting NOP bubbles or aborting, and captures each CBU result with its program index. It sits between the host/test harness and the CBU: its outputs drive `in`, `a` and `b`, and it samples the CBU's `out`.

## Interface
- DEPTH, 16: program entries (power of two)
- PC_W, 4: log2(DEPTH)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- prog_we  in  1  program write strobe; ignored while busy
- prog_addr  in  PC_W  program write address
- prog_data  in  17  [16:8] instruction (op[8:6], src1[5:4], src2[3:2], dst[1:0]), [7:4] a, [3:0] b
- start  in  1  begin run at entry 0; ignored while busy
- run_len  in  PC_W+1  entries to run, sampled with start; valid range 1..DEPTH
- cbu_in  out  9  instruction to CBU, registered
- cbu_a  out  4  operand a to CBU, registered
- cbu_b  out  4  operand b to CBU, registered
- cbu_out  in  4  CBU result
- result  out  4  captured result
- result_tag  out  PC_W  program index of result
- result_valid  out  1  one-cycle pulse
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at normal run end
- err  out  1  sticky illegal-instruction flag; cleared by the next accepted start
- stall_cnt  out  8  bubbles inserted in current run; saturates at 255

## Operation
- NOP = 9'b000_00_00_00 with a = b = 0. NOP is driven in IDLE, DRAIN and ABORT.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE → ISSUE on start with run_len in 1..DEPTH. pc ← 0, stall_cnt ← 0, err ← 0.
- start with run_len = 0 or run_len > DEPTH: err ← 1, stay IDLE, no done.
- ISSUE, each cycle: candidate = mem[pc]. Checks are applied in this order:
  - Illegal: candidate src1 = src2 ≠ 00. Set err, drive NOP, go to DRAIN (abort). No done pulse at the end of an aborted run.
  - Hazard: candidate src1 or src2 equals dst of the word currently on cbu_in, and that dst ≠ 00. Drive NOP, hold pc, stall_cnt++.
  - Otherwise: drive candidate, pc++. If pc reaches run_len−1 on this issue, go to DRAIN.
- A NOP never causes a hazard, so at most one consecutive bubble is inserted per entry.
- Result capture: every issued word with dst ≠ 00 pushes its pc into a 3-stage tag pipe. When a tag exits the pipe, result ← cbu_out, result_tag ← tag, result_valid pulses. Words with dst = 00 produce no result.
- DRAIN: drive NOP until the tag pipe is empty. Then pulse done (unless aborted), busy ← 0, go to IDLE.
- prog_we when not busy: mem[prog_addr] ← prog_data at the clock edge. Memory has no reset; its contents are undefined until written.

## Timing
- Reset asserted: state IDLE. cbu_in, cbu_a, cbu_b, result, result_tag, stall_cnt = 0. result_valid, busy, done, err = 0. Tag pipe cleared.
- Reset mid-run aborts immediately. No done; the CBU's own reset is the harness's concern.
- start sampled at edge S: busy = 1 after S. The first word appears on cbu_in after edge S+1.
- A word appears on cbu_in after edge E. The CBU registers it at E+1 and writes dst at E+2. The sequencer samples cbu_out at E+3, so result/result_valid update after E+3. Latency is 3 cycles from cbu_in change.
- Throughput: 1 word/cycle absent hazards.
- The last word appears after edge L. done pulses after edge L+3 (tag pipe empty) and busy falls at the same edge.
- start while busy is ignored. prog_we while busy is ignored, with no error.

## Structure
- Shared package cbu_pkg: NOP constant; field slice positions for op/src1/src2/dst; op enum (ADD=000 … MUL2=111); REG_NONE = 2'b00.
- Sub-module cbu_seq_mem: DEPTH×17 write-port/async-read program memory.
- Hazard/illegal checks and the FSM live in cbu_sequencer.

## Test plan
- Reset: assert rst low mid-sim → all outputs 0, busy 0; release → outputs stay 0 and state is IDLE.
- Single add: mem[0] = {000,01,10,11,a=3,b=4}, start with run_len = 1 → cbu_in = 9'h01B one cycle after start. result = 7, result_tag = 0, result_valid pulses 3 cycles later, done pulses once.
- Hazard: mem[0] = {000,01,10,11,3,4}, mem[1] = {001,11,01,10,9,2}, run_len = 2 → NOP between the two words, stall_cnt = 1. Results are 7 (tag 0) then 7 (tag 1).
- Illegal: mem[1] src1 = src2 = 10 → err = 1 and NOPs from that cycle. Only tag 0 produces a result, no done, busy falls after drain.
- Full length, no-dst words: 16 words, half with dst = 00, run_len = 16 → exactly 8 result_valid pulses with correct tags. start and prog_we during the run are ignored.
- Reset mid-run: rst low two cycles after start → busy 0 immediately, no result_valid/done. A fresh start reruns from pc 0.
